// File: rtl/cic_pkg.sv
// Shared CIC helpers used by both the receive decimator and the transmit
// interpolator.
//
// cic_reg_width(width, rmax, m, n)
//   Internal/output register width that holds the full CIC gain without loss:
//   width + clog2(((rmax*m)**n) / rmax).
package cic_pkg;

  function automatic int cic_reg_width(input int width, input int rmax,
                                       input int m, input int n);
    int gain;
    gain = 1;
    for (int i = 0; i < n; i++) begin
      gain = gain * (rmax * m);
    end
    return width + $clog2(gain / rmax);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y <= x - x delayed by M accepted samples.
// State only advances when en is high.
//
// Ports
//   clk  clock
//   rst  asynchronous active-high reset, clears output and delay line
//   en   advance the comb by one input sample
//   x    signed stage input
//   y    signed registered stage output
module cic_comb_stage #(
  parameter int REG_WIDTH = 17,
  parameter int M         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [REG_WIDTH-1:0] x,
  output logic signed [REG_WIDTH-1:0] y
);

  logic signed [REG_WIDTH-1:0] dly [M];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      for (int i = 0; i < M; i++) begin
        dly[i] <= '0;
      end
    end else if (en) begin
      // Two's-complement wrap is intentional; the integrators undo it.
      y      <= x - dly[M-1];
      dly[0] <= x;
      for (int i = 1; i < M; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by a
// runtime ratio R, then N integrators at the output rate. Output is not
// normalised (DC gain (R*M)^N / R).
//
// Ports
//   clk            clock
//   rst            asynchronous active-high reset
//   input_tdata    signed low-rate sample (WIDTH)
//   input_tvalid   input sample valid
//   input_tready   input accepted when high together with input_tvalid
//   output_tdata   signed high-rate sample, last integrator (REG_WIDTH)
//   output_tvalid  output sample valid
//   output_tready  downstream ready
//   rate           interpolation ratio; 0/1 mean R=1, >RMAX clamps to RMAX
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RMAX      = 2,
  parameter int M         = 1,
  parameter int N         = 2,
  parameter int REG_WIDTH = cic_reg_width(WIDTH, RMAX, M, N)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [WIDTH-1:0]       input_tdata,
  input  logic                          input_tvalid,
  output logic                          input_tready,
  output logic signed [REG_WIDTH-1:0]   output_tdata,
  output logic                          output_tvalid,
  input  logic                          output_tready,
  input  logic [$clog2(RMAX+1)-1:0]     rate
);

  localparam int RATE_W = $clog2(RMAX + 1);

  logic [RATE_W-1:0]           cycle_reg;
  logic [RATE_W-1:0]           rate_eff;
  logic [RATE_W-1:0]           rate_last;
  logic                        in_hs;
  logic                        out_hs;
  logic signed [REG_WIDTH-1:0] comb_x [N];
  logic signed [REG_WIDTH-1:0] comb_y [N];
  logic signed [REG_WIDTH-1:0] integ  [N];
  logic signed [REG_WIDTH-1:0] stuffed;

  function automatic logic signed [REG_WIDTH-1:0] wrap_add(
    input logic signed [REG_WIDTH-1:0] a,
    input logic signed [REG_WIDTH-1:0] b
  );
    // Plain modular sum: CIC correctness relies on wrap, never saturate.
    return a + b;
  endfunction

  always_comb begin
    rate_eff = rate;
    if (rate == '0) begin
      rate_eff = RATE_W'(1);
    end else if (int'(rate) > RMAX) begin
      rate_eff = RATE_W'(RMAX);
    end
    rate_last = rate_eff - RATE_W'(1);
  end

  // New input is only taken at the start of a burst (cycle_reg==0).
  assign input_tready  = output_tready & (cycle_reg == '0);
  assign output_tvalid = input_tvalid | (cycle_reg != '0);
  assign in_hs         = input_tvalid & input_tready;
  assign out_hs        = output_tvalid & output_tready;

  // The ">=" compare also wraps when rate was lowered mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_reg <= '0;
    end else if (out_hs) begin
      cycle_reg <= (cycle_reg < rate_last) ? cycle_reg + RATE_W'(1) : '0;
    end
  end

  // Comb chain, input rate
  for (genvar k = 0; k < N; k++) begin : g_comb
    if (k == 0) begin : g_head
      assign comb_x[k] = REG_WIDTH'(input_tdata);
    end else begin : g_link
      assign comb_x[k] = comb_y[k-1];
    end

    cic_comb_stage #(
      .REG_WIDTH (REG_WIDTH),
      .M         (M)
    ) u_comb (
      .clk (clk),
      .rst (rst),
      .en  (in_hs),
      .x   (comb_x[k]),
      .y   (comb_y[k])
    );
  end

  // Integrator chain, output rate; zero-stuff everywhere but burst start
  assign stuffed = (cycle_reg == '0) ? comb_y[N-1] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
      end
    end else if (out_hs) begin
      integ[0] <= wrap_add(integ[0], stuffed);
      for (int k = 1; k < N; k++) begin
        integ[k] <= wrap_add(integ[k], integ[k-1]);
      end
    end
  end

  assign output_tdata = integ[N-1];

endmodule

// File: tb/tb_cic_interpolator.sv
module tb_cic_interpolator;

  localparam int WIDTH = 16;
  localparam int RMAX  = 4;
  localparam int M_P   = 1;
  localparam int N_P   = 2;
  localparam int RW    = 18;  // 16 + clog2((4*1)**2 / 4)

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] input_tdata = '0;
  logic                    input_tvalid = 1'b0;
  logic                    input_tready;
  logic signed [RW-1:0]    output_tdata;
  logic                    output_tvalid;
  logic                    output_tready = 1'b0;
  logic [2:0]              rate = 3'd4;

  cic_interpolator #(
    .WIDTH     (WIDTH),
    .RMAX      (RMAX),
    .M         (M_P),
    .N         (N_P),
    .REG_WIDTH (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .input_tdata   (input_tdata),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .output_tdata  (output_tdata),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .rate          (rate)
  );

  always #5 clk = ~clk;

  int     in_q[$];
  longint out_q[$];
  longint exp_q[$];
  int     compared   = 0;
  int     mismatched = 0;
  int     bad_accept;
  int     tready_hi;
  int     tr_neq;
  int     cycles_run;
  bit     timed_out;

  function automatic longint wrapw(input longint v);
    longint m;
    m = v & ((longint'(1) << RW) - 1);
    if (m[RW-1]) m = m - (longint'(1) << RW);
    return m;
  endfunction

  function automatic int eff_rate(input int r);
    if (r <= 1) return 1;
    if (r > RMAX) return RMAX;
    return r;
  endfunction

  // Sequence-level reference: N-th difference of the input, one register of
  // delay per comb, zero-stuffed by R, then N running sums (each output is
  // the integrator state before that handshake).
  task automatic build_expected(input int r);
    longint d[$];
    longint nd[$];
    longint s[$];
    longint ns[$];
    longint acc;
    int l, k;
    l = in_q.size();
    k = l * r;
    d.delete();
    foreach (in_q[i]) d.push_back(longint'(in_q[i]));
    for (int st = 0; st < N_P; st++) begin
      nd.delete();
      for (int n = 0; n < l; n++)
        nd.push_back(wrapw(d[n] - ((n >= M_P) ? d[n-M_P] : 0)));
      d = nd;
    end
    s.delete();
    for (int j = 0; j < k; j++) begin
      if ((j % r) == 0 && (j / r) >= N_P) s.push_back(d[j/r - N_P]);
      else s.push_back(0);
    end
    for (int st = 0; st < N_P; st++) begin
      ns.delete();
      acc = 0;
      for (int j = 0; j < k; j++) begin
        ns.push_back(acc);
        acc = wrapw(acc + s[j]);
      end
      s = ns;
    end
    exp_q = s;
  endtask

  // Drives in_q with random valid/ready duty and records each output sample.
  task automatic drive(input int rate_val, input int rdy_pct, input int vld_pct,
                       input int target);
    int idx, phase, r, budget;
    idx = 0; phase = 0;
    r = eff_rate(rate_val);
    budget = target * 40 + 200;
    out_q.delete();
    bad_accept = 0; tready_hi = 0; tr_neq = 0; cycles_run = 0;
    while (out_q.size() < target && cycles_run < budget) begin
      @(negedge clk);
      rate = 3'(rate_val);
      output_tready = ($urandom_range(0, 99) < rdy_pct);
      if (idx < in_q.size() && $urandom_range(0, 99) < vld_pct) begin
        input_tvalid = 1'b1;
        input_tdata  = 16'(in_q[idx]);
      end else begin
        input_tvalid = 1'b0;
        input_tdata  = 16'($urandom);
      end
      #1;
      if (input_tready) tready_hi++;
      if (input_tready !== output_tready) tr_neq++;
      if (input_tvalid && input_tready) begin
        if (phase != 0) bad_accept++;
        idx++;
      end
      if (output_tvalid && output_tready) begin
        out_q.push_back(longint'(output_tdata));
        phase = (phase + 1) % r;
      end
      cycles_run++;
    end
    timed_out = (out_q.size() < target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    input_tvalid = 1'b0;
    output_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        @(negedge clk);
        rst = 1'b0;
      end
      input_tvalid  = i[0];
      output_tready = i[1];
      #1;
      compared++;
      if (output_tdata !== '0 || output_tvalid !== input_tvalid ||
          input_tready !== output_tready) begin
        mismatched++;
        $display("FAIL reset[%0d]: tdata=%0d tvalid=%b tready=%b required 0/%b/%b",
                 i, output_tdata, output_tvalid, input_tready, input_tvalid, output_tready);
      end
    end
    input_tvalid = 1'b0;
    output_tready = 1'b0;
  endtask

  task automatic test_impulse();
    int tab[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    longint sum;
    do_reset();
    in_q = '{1, 0, 0, 0, 0, 0};
    build_expected(4);
    drive(4, 100, 100, exp_q.size());
    compared++;
    if (timed_out) begin
      mismatched++;
      $display("FAIL impulse_timeout: got %0d samples required %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      compared++;
      if (out_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL impulse[%0d]: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
    sum = 0;
    for (int i = 0; i < 8 && 10 + i < out_q.size(); i++) begin
      sum += out_q[10+i];
      compared++;
      if (out_q[10+i] !== longint'(tab[i])) begin
        mismatched++;
        $display("FAIL impulse_tap[%0d]: got %0d required %0d", 10 + i, out_q[10+i], tab[i]);
      end
    end
    compared++;
    if (sum !== 16) begin
      mismatched++;
      $display("FAIL impulse_sum: got %0d required 16", sum);
    end
  endtask

  task automatic test_dc();
    do_reset();
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(100);
    build_expected(4);
    drive(4, 100, 100, exp_q.size());
    compared++;
    if (timed_out || tready_hi * 4 != cycles_run) begin
      mismatched++;
      $display("FAIL dc_tready: got %0d ready cycles of %0d required 1 in 4",
               tready_hi, cycles_run);
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      compared++;
      if (out_q[i] !== exp_q[i] || (i >= 16 && out_q[i] !== 400)) begin
        mismatched++;
        $display("FAIL dc[%0d]: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rate_edges();
    int rates[3] = '{0, 1, 7};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      in_q.delete();
      for (int i = 0; i < 8; i++) in_q.push_back(int'($urandom_range(0, 4000)) - 2000);
      build_expected(eff_rate(rates[t]));
      drive(rates[t], (rates[t] == 7) ? 100 : 70, 80, exp_q.size());
      compared++;
      if (timed_out || (rates[t] <= 1 && tr_neq != 0)) begin
        mismatched++;
        $display("FAIL rate%0d_ready: got %0d ready mismatches timeout=%0d required 0",
                 rates[t], tr_neq, timed_out);
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
        compared++;
        if (out_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL rate%0d[%0d]: got %0d required %0d", rates[t], i, out_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_q.delete();
    for (int i = 0; i < 12; i++) in_q.push_back(int'($urandom_range(0, 20000)) - 10000);
    build_expected(4);
    drive(4, 30, 50, exp_q.size());
    compared++;
    if (timed_out || bad_accept != 0) begin
      mismatched++;
      $display("FAIL backpressure_accept: got %0d mid-burst accepts timeout=%0d required 0",
               bad_accept, timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      compared++;
      if (out_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL backpressure[%0d]: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int fs[3] = '{32767, -32767, -32768};
    for (int t = 0; t < 2; t++) begin
      do_reset();
      in_q.delete();
      for (int i = 0; i < 14; i++) begin
        if (t == 0) in_q.push_back((i % 2) ? -32767 : 32767);
        else in_q.push_back(fs[$urandom_range(0, 2)]);
      end
      build_expected(4 - t);
      drive(4 - t, 100, 100, exp_q.size());
      compared++;
      if (timed_out) begin
        mismatched++;
        $display("FAIL wrap%0d_timeout: got %0d samples required %0d", t, out_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
        compared++;
        if (out_q[i] !== exp_q[i]) begin
          mismatched++;
          $display("FAIL wrap%0d[%0d]: got %0d required %0d", t, i, out_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_q.delete();
    for (int i = 0; i < 6; i++) in_q.push_back(int'($urandom_range(1000, 9000)));
    drive(4, 100, 100, 14);  // stop with cycle_reg at 2
    @(negedge clk);
    output_tready = 1'b0;
    input_tvalid  = 1'b0;
    #1;
    compared++;
    if (output_tvalid !== 1'b1 || input_tready !== 1'b0) begin
      mismatched++;
      $display("FAIL midburst_valid: got tvalid=%b tready=%b required 1/0", output_tvalid, input_tready);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (output_tdata !== '0 || output_tvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got tdata=%0d tvalid=%b required 0/0", output_tdata, output_tvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    output_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++;
      if (output_tvalid !== 1'b0 || output_tdata !== '0) begin
        mismatched++;
        $display("FAIL post_reset_idle[%0d]: got tvalid=%b tdata=%0d required 0/0",
                 i, output_tvalid, output_tdata);
      end
      @(negedge clk);
    end
    in_q.delete();
    for (int i = 0; i < 6; i++) in_q.push_back(int'($urandom_range(0, 30000)) - 15000);
    build_expected(4);
    drive(4, 100, 100, exp_q.size());
    compared++;
    if (timed_out) begin
      mismatched++;
      $display("FAIL post_reset_timeout: got %0d samples required %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      compared++;
      if (out_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL post_reset[%0d]: got %0d required %0d", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_rate_edges();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
